// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared bitwise logic unit.
// Each granted operation runs IDLE -> EXEC -> DONE in fixed three cycles.
module logic_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [3*N_REQ-1:0]     op_flat,
  input  logic [WIDTH*N_REQ-1:0] a_flat,
  input  logic [WIDTH*N_REQ-1:0] b_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic                   err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [IW-1:0] idx_t;

  state_t             state_q, state_d;
  idx_t               ptr_q, ptr_d;
  idx_t               win_q, win_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [2:0]         op_arr [N_REQ];
  logic [WIDTH-1:0]   a_arr  [N_REQ];
  logic [WIDTH-1:0]   b_arr  [N_REQ];

  logic               win_found;
  idx_t               win_idx;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_err;

  // Index p+k, wrapped into 0..N_REQ-1.
  function automatic idx_t wrap_add(idx_t p, int k);
    int c;
    c = int'(p) + k;
    if (c >= N_REQ) c = c - N_REQ;
    return idx_t'(c);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(idx_t i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Split the flat request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      op_arr[i] = op_flat[3*i +: 3];
      a_arr[i]  = a_flat[WIDTH*i +: WIDTH];
      b_arr[i]  = b_flat[WIDTH*i +: WIDTH];
    end
  end

  // First asserted request at or after ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req[wrap_add(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Bitwise logic unit on the latched operands; 111 is illegal.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (op_q)
      3'b000:  alu_res = a_q & b_q;
      3'b001:  alu_res = a_q | b_q;
      3'b010:  alu_res = a_q ^ b_q;
      3'b011:  alu_res = ~a_q;
      3'b100:  alu_res = ~(a_q | b_q);
      3'b101:  alu_res = ~(a_q & b_q);
      3'b110:  alu_res = ~(a_q ^ b_q);
      default: alu_err = 1'b1;
    endcase
  end

  // Next-state and registered-output logic of the three-state FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = 1'b0;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d = EXEC;
          win_d   = win_idx;
          gnt_d   = onehot(win_idx);
          op_d    = op_arr[win_idx];
          a_d     = a_arr[win_idx];
          b_d     = b_arr[win_idx];
        end
      end
      EXEC: begin
        state_d  = DONE;
        done_d   = onehot(win_q);
        err_d    = alu_err;
        result_d = alu_res;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (win_q == idx_t'(N_REQ - 1)) ? '0 : win_q + idx_t'(1);
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table plus
// hand sequences for rotation, reset abort and operand latching.
module tb_logic_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [3*N-1:0] op_flat;
  logic [W*N-1:0] a_flat;
  logic [W*N-1:0] b_flat;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;
  logic           err;

  int checks   = 0;
  int failures = 0;

  logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op_flat (op_flat),
    .a_flat  (a_flat),
    .b_flat  (b_flat),
    .gnt     (gnt),
    .done    (done),
    .result  (result),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [N-1:0] gnt;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    req     = r;
    op_flat = {N{o}};
    a_flat  = {N{a}};
    b_flat  = {N{b}};
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // One full operation; inputs are scrambled and req dropped in EXEC.
  task automatic run_vec(input int i);
    logic [W-1:0] res_exp;
    @(negedge clk);
    drive(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b);
    @(posedge clk); #1;
    chk($sformatf("v%0d_exec_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
    chk($sformatf("v%0d_exec_busy", i), 32'(busy), 32'h1);
    chk($sformatf("v%0d_exec_done", i), 32'(done), 32'h0);
    drive('0, 3'b111, ~vecs[i].a, ~vecs[i].b);
    @(posedge clk); #1;
    chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].gnt));
    chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
    chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
    chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
    res_exp = vecs[i].res;
    @(posedge clk); #1;
    chk_idle_zero($sformatf("v%0d_idle", i));
    chk($sformatf("v%0d_hold", i), 32'(result), 32'(res_exp));
  endtask

  logic [N-1:0] exp_done;

  initial begin
    // ptr starts at 0 and advances to winner+1 after each vector.
    vecs[0]  = '{4'b0001, 3'b000, 8'h0F, 8'hAA, 4'b0001, 8'h0A, 1'b0};
    vecs[1]  = '{4'b0100, 3'b011, 8'hF0, 8'h55, 4'b0100, 8'h0F, 1'b0};
    vecs[2]  = '{4'b0100, 3'b110, 8'hAA, 8'h55, 4'b0100, 8'h00, 1'b0};
    vecs[3]  = '{4'b0010, 3'b111, 8'hFF, 8'hFF, 4'b0010, 8'h00, 1'b1};
    vecs[4]  = '{4'b0010, 3'b101, 8'h00, 8'hFF, 4'b0010, 8'hFF, 1'b0};
    vecs[5]  = '{4'b1000, 3'b001, 8'h0C, 8'h30, 4'b1000, 8'h3C, 1'b0};
    vecs[6]  = '{4'b1000, 3'b010, 8'hFF, 8'h0F, 4'b1000, 8'hF0, 1'b0};
    vecs[7]  = '{4'b0001, 3'b100, 8'h0F, 8'hAA, 4'b0001, 8'h50, 1'b0};
    vecs[8]  = '{4'b1001, 3'b000, 8'hF0, 8'h3C, 4'b1000, 8'h30, 1'b0};
    vecs[9]  = '{4'b1001, 3'b001, 8'h01, 8'h80, 4'b0001, 8'h81, 1'b0};
    vecs[10] = '{4'b0011, 3'b010, 8'h5A, 8'h5A, 4'b0010, 8'h00, 1'b0};
    vecs[11] = '{4'b0011, 3'b101, 8'hFF, 8'hFF, 4'b0001, 8'h00, 1'b0};

    rst = 1'b1;
    drive('0, 3'b000, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    chk("reset_result", 32'(result), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_noreq_gnt", 32'(gnt), 32'h0);
    chk("idle_noreq_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 12; i++) run_vec(i);

    // Rotation under continuous requests, held through reset.
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1111, 3'b001, 8'h11, 8'h22);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      exp_done = '0;
      if (c % 3 == 2) exp_done[(c / 3) % N] = 1'b1;
      chk($sformatf("rot_c%0d_done", c), 32'(done), 32'(exp_done));
      chk($sformatf("rot_c%0d_gnt1h", c), 32'($countones(gnt) <= 1), 32'h1);
      chk($sformatf("rot_c%0d_busy", c), 32'(busy), 32'(c % 3 != 0));
    end

    // Reset during EXEC aborts the op and returns ptr to 0.
    @(negedge clk);
    rst = 1'b1;
    drive('0, 3'b100, 8'h0F, 8'hAA);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0001;
    @(posedge clk); #1;
    chk("ab_pre_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req = 4'b0011;
    @(posedge clk); #1;
    chk("ab_exec_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_zero("ab_rst");
    chk("ab_rst_result", 32'(result), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ab_regnt", 32'(gnt), 32'h1);
    chk("ab_regnt_done", 32'(done), 32'h0);
    req = '0;
    @(posedge clk); #1;
    chk("ab_done", 32'(done), 32'h1);
    chk("ab_result", 32'(result), 32'h50);
    chk("ab_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    chk_idle_zero("ab_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  N_REQ  SHALL be the per-requester operation request, bit i = requester i.
REQ-006 op_flat  input  3*N_REQ  SHALL carry requester i's opcode in bits [3i+2:3i].
REQ-007 a_flat  input  WIDTH*N_REQ  SHALL carry requester i's operand A in slice i.
REQ-008 b_flat  input  WIDTH*N_REQ  SHALL carry requester i's operand B in slice i.
REQ-009 gnt  output  N_REQ  SHALL be the one-hot grant to the requester being served.
REQ-010 done  output  N_REQ  SHALL be a one-hot, one-cycle completion pulse to the served requester.
REQ-011 result  output  WIDTH  SHALL be the registered result of the last completed operation.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 err  output  1  SHALL pulse high together with done when the completed opcode was illegal.

Function
REQ-014 Opcodes SHALL be: 000 AND, 001 OR, 010 XOR, 011 NOT A (B ignored), 100 NOR, 101 NAND, 110 XNOR, 111 illegal.
REQ-015 All logic operations SHALL be bitwise over WIDTH bits; an illegal opcode SHALL yield result 0 and err=1.
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-017 IDLE: with req==0, the FSM SHALL remain in IDLE with gnt=0, done=0.
REQ-018 IDLE: with req!=0, the winner SHALL be the first set req bit searched from index ptr upward, wrapping at N_REQ-1 to 0.
REQ-019 On the IDLE->EXEC edge, gnt SHALL become onehot(winner) and the winner's opcode, A and B SHALL be latched internally.
REQ-020 EXEC->DONE SHALL occur unconditionally after one cycle; on that edge, result and err SHALL be loaded from the latched operands and done SHALL become onehot(winner).
REQ-021 DONE->IDLE SHALL occur unconditionally after one cycle; on that edge gnt, done and err SHALL return to 0 and ptr SHALL become (winner+1) mod N_REQ.
REQ-022 Latency SHALL be fixed: req sampled high in IDLE at edge t gives gnt high from t+1, done high in cycle t+2 only, and the FSM back in IDLE at t+3.
REQ-023 Peak throughput SHALL be one operation per 3 cycles.
REQ-024 Changes to req, op or operands after the IDLE->EXEC edge SHALL NOT affect the operation in flight; dropping req SHALL NOT abort it.
REQ-025 A requester still asserting req in the IDLE cycle after its done SHALL be re-arbitrated, with lowest priority.
REQ-026 Under continuous requests from all N_REQ requesters, grants SHALL rotate strictly so that no requester waits more than N_REQ operations.
REQ-027 result SHALL hold its value between done pulses; done and err SHALL never be high outside DONE.
REQ-028 gnt SHALL be high in exactly the EXEC and DONE cycles of the served requester and SHALL never have more than one bit set.

Reset
REQ-029 rst=1 at a clock edge SHALL force: state IDLE, ptr=0, gnt=0, done=0, err=0, busy=0, result=0.
REQ-030 rst SHALL take priority over every transition; reset in EXEC or DONE SHALL abort the operation with no done pulse, and ptr SHALL return to 0.
REQ-031 Requests held through reset SHALL be arbitrated normally starting in the first IDLE cycle after rst falls.

Verification
REQ-032 req=0001, op0=000, A0=0x0F, B0=0xAA -> gnt=0001 for two cycles, done=0001 for one cycle, result=0x0A, err=0.
REQ-033 req=1111 held, every requester op=001 -> done order 0,1,2,3,0 with one done every 3 cycles and gnt always one-hot.
REQ-034 Requester 2 only, op=011, A=0xF0, B=0x55 -> result=0x0F (B ignored); then op=110, A=0xAA, B=0x55 -> result=0x00.
REQ-035 Requester 1 only, op=111, A=0xFF, B=0xFF -> done=0010, err=1 for one cycle, result=0x00; next op=101, A=0x00, B=0xFF -> result=0xFF, err=0.
REQ-036 Requester 0 issues op=100, A=0x0F, B=0xAA; rst=1 for one cycle during EXEC -> no done pulse, all outputs 0, ptr=0; req still held -> a new grant to requester 0 after rst falls.
REQ-037 Requester 3 wins, then its op and A/B are changed while in EXEC -> result reflects the values latched at grant.
